// File: rtl/wt_mem_req_arbiter.sv
// N-channel request arbiter and return router between L1 cache clients and
// a single memory-adapter port. One output register stage holds the granted
// request; returns are routed combinationally by the source field of the ID.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | output register free, mem_req_valid_o low
//   ST_FULL  | output register holds a granted request, mem_req_valid_o high
module wt_mem_req_arbiter #(
   parameter int unsigned NumReq         = 3,
   parameter int unsigned TxIdWidth      = 2,
   parameter int unsigned PayloadWidth   = 96,
   parameter int unsigned RtrnWidth      = 128,
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          FixedPrio      = 1'b0,
   localparam int unsigned SrcW          = $clog2(NumReq),
   localparam int unsigned IdW           = SrcW + TxIdWidth
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumReq-1:0]              req_i,
   output logic [NumReq-1:0]              ack_o,
   input  logic [NumReq*PayloadWidth-1:0] req_data_i,
   input  logic [NumReq*TxIdWidth-1:0]    req_txid_i,
   output logic                           mem_req_valid_o,
   input  logic                           mem_req_ready_i,
   output logic [PayloadWidth-1:0]        mem_req_data_o,
   output logic [IdW-1:0]                 mem_req_id_o,
   input  logic                           mem_rtrn_valid_i,
   input  logic [IdW-1:0]                 mem_rtrn_id_i,
   input  logic                           mem_rtrn_last_i,
   input  logic [RtrnWidth-1:0]           mem_rtrn_data_i,
   output logic [NumReq-1:0]              rtrn_vld_o,
   output logic [TxIdWidth-1:0]           rtrn_txid_o,
   output logic [RtrnWidth-1:0]           rtrn_data_o,
   output logic                           idle_o,
   output logic                           rtrn_err_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   typedef enum logic {ST_EMPTY, ST_FULL} state_e;

   state_e                  state_q, state_d;
   logic [PayloadWidth-1:0] data_q, data_d;
   logic [IdW-1:0]          id_q, id_d;
   logic [SrcW-1:0]         rr_q, rr_d;
   logic                    err_q, err_d;
   logic [CntW-1:0]         cnt_q [NumReq];
   logic [CntW-1:0]         cnt_d [NumReq];

   logic [NumReq-1:0]       elig;
   logic                    gnt_found;
   logic [SrcW-1:0]         gnt_idx;
   int unsigned             scan_idx;
   logic                    grant;
   logic [SrcW-1:0]         rtrn_src;
   logic                    rtrn_legal;

   assign rtrn_src   = mem_rtrn_id_i[IdW-1 -: SrcW];
   assign rtrn_legal = 32'(rtrn_src) < NumReq;

   // a requestor competes only while it is below its in-flight limit
   always_comb begin
      for (int k = 0; k < NumReq; k++) begin
         elig[k] = req_i[k] && (cnt_q[k] < MaxCnt);
      end
   end

   // pick the winner: lowest index, or first eligible at/after the RR pointer
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = 0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         scan_idx = FixedPrio ? i : (i + 32'(rr_q)) % NumReq;
         if (!gnt_found && elig[SrcW'(scan_idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = SrcW'(scan_idx);
         end
      end
   end

   // a grant needs a free output register or one being drained this cycle
   assign grant = gnt_found && !rst_i && (state_q == ST_EMPTY || mem_req_ready_i);

   // single-cycle one-hot acknowledge of the grant
   always_comb begin
      ack_o = '0;
      if (grant) ack_o[gnt_idx] = 1'b1;
   end

   // output stage next state, latched payload/id and RR pointer advance
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      rr_d    = rr_q;
      unique case (state_q)
         ST_EMPTY: if (grant) state_d = ST_FULL;
         ST_FULL:  if (mem_req_ready_i && !grant) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (grant) begin
         data_d = req_data_i[32'(gnt_idx)*PayloadWidth +: PayloadWidth];
         id_d   = {gnt_idx, req_txid_i[32'(gnt_idx)*TxIdWidth +: TxIdWidth]};
         rr_d   = (gnt_idx == SrcW'(NumReq - 1)) ? '0 : gnt_idx + SrcW'(1);
      end
   end

   // outstanding counters: saturating decrement first, then grant increment,
   // so a simultaneous grant and last-return for the same source cancel out
   always_comb begin
      err_d = err_q;
      if (mem_rtrn_valid_i && !rtrn_legal) err_d = 1'b1;
      for (int k = 0; k < NumReq; k++) begin
         cnt_d[k] = cnt_q[k];
         if (mem_rtrn_valid_i && mem_rtrn_last_i && rtrn_legal && rtrn_src == SrcW'(k)) begin
            if (cnt_q[k] == '0) err_d = 1'b1;
            else cnt_d[k] = cnt_q[k] - CntW'(1);
         end
         if (grant && gnt_idx == SrcW'(k)) cnt_d[k] = cnt_d[k] + CntW'(1);
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         rr_q    <= '0;
         err_q   <= 1'b0;
         for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         err_q   <= err_d;
         for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   // zero-latency return routing; illegal sources are not forwarded
   always_comb begin
      rtrn_vld_o = '0;
      if (mem_rtrn_valid_i && rtrn_legal && !rst_i) rtrn_vld_o[rtrn_src] = 1'b1;
   end

   // idle only when nothing is in flight and the output register is free
   always_comb begin
      idle_o = (state_q == ST_EMPTY);
      for (int k = 0; k < NumReq; k++) begin
         if (cnt_q[k] != '0) idle_o = 1'b0;
      end
   end

   assign mem_req_valid_o = (state_q == ST_FULL);
   assign mem_req_data_o  = data_q;
   assign mem_req_id_o    = id_q;
   assign rtrn_txid_o     = mem_rtrn_id_i[TxIdWidth-1:0];
   assign rtrn_data_o     = mem_rtrn_data_i;
   assign rtrn_err_o      = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Bench for wt_mem_req_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1) are checked every cycle against a
// queue-based model of in-flight transactions, with directed scenarios
// pinning literal expectations followed by a randomized phase.
module tb_wt_mem_req_arbiter;

   localparam int N  = 3;
   localparam int TW = 2;
   localparam int PW = 96;
   localparam int RW = 128;
   localparam int MO = 2;
   localparam int SW = 2;
   localparam int IW = SW + TW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst   [2];
   logic [N-1:0]    req   [2];
   logic [N*PW-1:0] rdat  [2];
   logic [N*TW-1:0] rtx   [2];
   logic            rdy   [2];
   logic            rv    [2];
   logic [IW-1:0]   rid   [2];
   logic            rlast [2];
   logic [RW-1:0]   rrd   [2];

   logic [N-1:0]    o_ack   [2];
   logic            o_mval  [2];
   logic [PW-1:0]   o_mdat  [2];
   logic [IW-1:0]   o_mid   [2];
   logic [N-1:0]    o_rvld  [2];
   logic [TW-1:0]   o_rtx   [2];
   logic [RW-1:0]   o_rdat  [2];
   logic            o_idle  [2];
   logic            o_err   [2];

   wt_mem_req_arbiter #(.NumReq(N), .TxIdWidth(TW), .PayloadWidth(PW), .RtrnWidth(RW),
                        .MaxOutstanding(MO), .FixedPrio(1'b0)) u_rr (
      .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .ack_o(o_ack[0]),
      .req_data_i(rdat[0]), .req_txid_i(rtx[0]),
      .mem_req_valid_o(o_mval[0]), .mem_req_ready_i(rdy[0]),
      .mem_req_data_o(o_mdat[0]), .mem_req_id_o(o_mid[0]),
      .mem_rtrn_valid_i(rv[0]), .mem_rtrn_id_i(rid[0]), .mem_rtrn_last_i(rlast[0]),
      .mem_rtrn_data_i(rrd[0]), .rtrn_vld_o(o_rvld[0]), .rtrn_txid_o(o_rtx[0]),
      .rtrn_data_o(o_rdat[0]), .idle_o(o_idle[0]), .rtrn_err_o(o_err[0]));

   wt_mem_req_arbiter #(.NumReq(N), .TxIdWidth(TW), .PayloadWidth(PW), .RtrnWidth(RW),
                        .MaxOutstanding(MO), .FixedPrio(1'b1)) u_fp (
      .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .ack_o(o_ack[1]),
      .req_data_i(rdat[1]), .req_txid_i(rtx[1]),
      .mem_req_valid_o(o_mval[1]), .mem_req_ready_i(rdy[1]),
      .mem_req_data_o(o_mdat[1]), .mem_req_id_o(o_mid[1]),
      .mem_rtrn_valid_i(rv[1]), .mem_rtrn_id_i(rid[1]), .mem_rtrn_last_i(rlast[1]),
      .mem_rtrn_data_i(rrd[1]), .rtrn_vld_o(o_rvld[1]), .rtrn_txid_o(o_rtx[1]),
      .rtrn_data_o(o_rdat[1]), .idle_o(o_idle[1]), .rtrn_err_o(o_err[1]));

   // model: per requestor, a queue of in-flight txids; plus the output register
   int            outs   [2][N][$];
   bit            m_full [2];
   logic [PW-1:0] m_data [2];
   logic [IW-1:0] m_id   [2];
   int            m_rr   [2];
   bit            m_err  [2];
   bit            acked  [2][N];
   logic [IW-1:0] issued [2][$];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // who the model says wins this cycle (-1 for nobody)
   function automatic int winner(int d);
      if (rst[d]) return -1;
      if (m_full[d] && !rdy[d]) return -1;
      for (int i = 0; i < N; i++) begin
         int k = (d == 1) ? i : (m_rr[d] + i) % N;
         if (req[d][k] && outs[d][k].size() < MO) return k;
      end
      return -1;
   endfunction

   // model state update at the active edge
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int g;
         int src;
         int pos;
         g = winner(d);
         for (int k = 0; k < N; k++) acked[d][k] = 1'b0;
         if (rst[d]) begin
            m_full[d] = 1'b0;
            m_rr[d]   = 0;
            m_err[d]  = 1'b0;
            for (int k = 0; k < N; k++) outs[d][k].delete();
            issued[d].delete();
         end else begin
            src = int'(rid[d][IW-1 -: SW]);
            if (rv[d]) begin
               if (src >= N) m_err[d] = 1'b1;
               else if (rlast[d]) begin
                  if (outs[d][src].size() == 0) m_err[d] = 1'b1;
                  else begin
                     pos = 0;
                     for (int j = 0; j < outs[d][src].size(); j++)
                        if (outs[d][src][j] == int'(rid[d][TW-1:0])) pos = j;
                     outs[d][src].delete(pos);
                  end
               end
            end
            if (m_full[d] && rdy[d]) issued[d].push_back(m_id[d]);
            if (g >= 0) begin
               outs[d][g].push_back(int'(rtx[d][g*TW +: TW]));
               m_full[d]   = 1'b1;
               m_data[d]   = rdat[d][g*PW +: PW];
               m_id[d]     = {SW'(g), rtx[d][g*TW +: TW]};
               acked[d][g] = 1'b1;
               m_rr[d]     = (g + 1) % N;
            end else if (m_full[d] && rdy[d]) begin
               m_full[d] = 1'b0;
            end
         end
      end
   end

   // compare every output against the model mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            int g;
            int src;
            logic [N-1:0] eack;
            logic [N-1:0] evld;
            bit idl;
            g = winner(d);
            eack = '0;
            if (g >= 0) eack[g] = 1'b1;
            chk($sformatf("d%0d_ack", d), o_ack[d], eack);
            chk($sformatf("d%0d_mval", d), o_mval[d], m_full[d]);
            if (m_full[d]) begin
               chk($sformatf("d%0d_mdat", d), o_mdat[d], m_data[d]);
               chk($sformatf("d%0d_mid", d), o_mid[d], m_id[d]);
            end
            src = int'(rid[d][IW-1 -: SW]);
            evld = '0;
            if (rv[d] && !rst[d] && src < N) evld[src] = 1'b1;
            chk($sformatf("d%0d_rvld", d), o_rvld[d], evld);
            if (rv[d]) begin
               chk($sformatf("d%0d_rtxid", d), o_rtx[d], rid[d][TW-1:0]);
               chk($sformatf("d%0d_rdata", d), o_rdat[d], rrd[d]);
            end
            idl = !m_full[d];
            for (int k = 0; k < N; k++) if (outs[d][k].size() != 0) idl = 1'b0;
            chk($sformatf("d%0d_idle", d), o_idle[d], idl);
            chk($sformatf("d%0d_err", d), o_err[d], m_err[d]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input int d);
      rst[d] = 1'b1; req[d] = '0; rv[d] = 1'b0; rlast[d] = 1'b0;
      step();
      rst[d] = 1'b0;
   endtask

   task automatic new_payload(input int d, input int k);
      rdat[d][k*PW +: PW] = {$urandom, $urandom, $urandom};
      rtx[d][k*TW +: TW]  = TW'($urandom);
   endtask

   initial begin
      int nack;
      logic [PW-1:0] pat1;
      logic [PW-1:0] pat2;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = '0; rdat[d] = '0; rtx[d] = '0; rdy[d] = 1'b0;
         rv[d] = 1'b0; rid[d] = '0; rlast[d] = 1'b0; rrd[d] = '0;
      end
      step();
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk_en = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_idle", o_idle[0], 1'b1);
      chk("rst_mval", o_mval[0], 1'b0);
      chk("rst_err", o_err[0], 1'b0);
      chk("rst_ack", o_ack[0], 3'b000);
      step();

      // round-robin fairness with immediate returns
      rdy[0] = 1'b1;
      for (int k = 0; k < N; k++) begin
         rtx[0][k*TW +: TW] = TW'(k);
         rdat[0][k*PW +: PW] = PW'(k + 16);
      end
      req[0] = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_ack", o_ack[0], 3'b001 << (i % 3));
         if (i > 0) chk("rr_src", o_mid[0][IW-1 -: SW], (i - 1) % 3);
         step();
         rv[0] = 1'b1; rlast[0] = 1'b1; rid[0] = {SW'(i % 3), TW'(i % 3)};
      end
      req[0] = '0;
      @(negedge clk);
      chk("rr_src", o_mid[0][IW-1 -: SW], 2);
      step();
      rv[0] = 1'b0;
      @(negedge clk);
      chk("rr_idle", o_idle[0], 1'b1);
      step();

      // fixed priority on the second instance
      reset_dut(1);
      rdy[1] = 1'b1;
      req[1] = 3'b110;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("fp_ack", o_ack[1], (i < 2) ? 3'b010 : (i < 4) ? 3'b100 : 3'b000);
         step();
      end
      req[1] = 3'b111;
      @(negedge clk);
      chk("fp_ack_req0", o_ack[1], 3'b001);
      step();
      reset_dut(1);

      // outstanding limit
      reset_dut(0);
      rdy[0] = 1'b1; req[0] = 3'b001; rtx[0][TW-1:0] = 2'd1;
      nack = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (o_ack[0][0]) nack++;
         step();
      end
      chk("lim_acks", nack, 2);
      rv[0] = 1'b1; rlast[0] = 1'b1; rid[0] = {2'd0, 2'd1};
      @(negedge clk);
      chk("lim_ack_ret", o_ack[0], 3'b000);
      step();
      rv[0] = 1'b0; rlast[0] = 1'b0;
      @(negedge clk);
      chk("lim_ack_after", o_ack[0], 3'b001);
      step();
      @(negedge clk);
      chk("lim_ack_blocked", o_ack[0], 3'b000);
      step();

      // backpressure holds the output register
      reset_dut(0);
      pat1 = {32'hA5A5_0001, 32'h1234_5678, 32'hDEAD_BEEF};
      pat2 = {32'h5A5A_0002, 32'h8765_4321, 32'hCAFE_F00D};
      rdy[0] = 1'b0; req[0] = 3'b001; rdat[0][PW-1:0] = pat1; rtx[0][TW-1:0] = 2'd2;
      @(negedge clk);
      chk("bp_ack0", o_ack[0], 3'b001);
      step();
      rdat[0][PW-1:0] = pat2; rtx[0][TW-1:0] = 2'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_mval", o_mval[0], 1'b1);
         chk("bp_mdat", o_mdat[0], pat1);
         chk("bp_mid", o_mid[0], 4'b0010);
         chk("bp_noack", o_ack[0], 3'b000);
         step();
      end
      rdy[0] = 1'b1;
      @(negedge clk);
      chk("bp_b2b_ack", o_ack[0], 3'b001);
      step();
      req[0] = '0;
      @(negedge clk);
      chk("bp_mdat2", o_mdat[0], pat2);
      chk("bp_mid2", o_mid[0], 4'b0011);
      step();

      // return routing coinciding with a grant to the same source
      reset_dut(0);
      rdy[0] = 1'b1; req[0] = 3'b100; rtx[0][2*TW +: TW] = 2'd1;
      @(negedge clk);
      chk("rt_ack0", o_ack[0], 3'b100);
      step();
      rv[0] = 1'b1; rlast[0] = 1'b1; rid[0] = {2'd2, 2'b11}; rrd[0] = {4{32'h0BAD_F00D}};
      @(negedge clk);
      chk("rt_rvld", o_rvld[0], 3'b100);
      chk("rt_txid", o_rtx[0], 2'd3);
      chk("rt_rdat", o_rdat[0], {4{32'h0BAD_F00D}});
      chk("rt_ack1", o_ack[0], 3'b100);
      step();
      req[0] = '0; rv[0] = 1'b0; rlast[0] = 1'b0;
      step();
      @(negedge clk);
      chk("rt_cnt_kept", o_idle[0], 1'b0);
      rv[0] = 1'b1; rlast[0] = 1'b1; rid[0] = {2'd2, 2'd1};
      step();
      rid[0] = {2'd3, 2'd0}; rlast[0] = 1'b1;
      @(negedge clk);
      chk("rt_idle", o_idle[0], 1'b1);
      chk("rt_noerr", o_err[0], 1'b0);
      chk("rt_bad_rvld", o_rvld[0], 3'b000);
      step();
      rv[0] = 1'b0; rlast[0] = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("rt_err_sticky", o_err[0], 1'b1);
      step();

      // reset while FULL with requests in flight
      reset_dut(0);
      rdy[0] = 1'b1; req[0] = 3'b010;
      step();
      step();
      req[0] = 3'b001;
      @(negedge clk);
      chk("mr_ack0", o_ack[0], 3'b001);
      step();
      req[0] = '0; rdy[0] = 1'b0;
      @(negedge clk);
      chk("mr_full", o_mval[0], 1'b1);
      chk("mr_busy", o_idle[0], 1'b0);
      step();
      rst[0] = 1'b1;
      step();
      rst[0] = 1'b0;
      @(negedge clk);
      chk("mr_mval", o_mval[0], 1'b0);
      chk("mr_idle", o_idle[0], 1'b1);
      step();
      rv[0] = 1'b1; rlast[0] = 1'b1; rid[0] = {2'd1, 2'd0};
      step();
      rv[0] = 1'b0; rlast[0] = 1'b0;
      @(negedge clk);
      chk("mr_err", o_err[0], 1'b1);
      step();

      // randomized traffic on both instances
      reset_dut(0);
      reset_dut(1);
      for (int c = 0; c < 3000; c++) begin
         for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rlast[d] = 1'b0;
            if (!rst[d] && $urandom_range(0, 399) == 0) begin
               rst[d] = 1'b1; req[d] = '0;
            end else begin
               rst[d] = 1'b0;
               for (int k = 0; k < N; k++) begin
                  if (req[d][k]) begin
                     if (acked[d][k]) begin
                        req[d][k] = 1'($urandom_range(0, 1));
                        if (req[d][k]) new_payload(d, k);
                     end
                  end else if ($urandom_range(0, 2) == 0) begin
                     req[d][k] = 1'b1;
                     new_payload(d, k);
                  end
               end
               rdy[d] = ($urandom_range(0, 9) < 7);
               rrd[d] = {$urandom, $urandom, $urandom, $urandom};
               if (issued[d].size() > 0 && $urandom_range(0, 9) < 4) begin
                  int ix;
                  ix = int'($urandom_range(0, issued[d].size() - 1));
                  rv[d] = 1'b1;
                  rid[d] = issued[d][ix];
                  rlast[d] = 1'($urandom_range(0, 1));
                  if (rlast[d]) issued[d].delete(ix);
               end else if ($urandom_range(0, 149) == 0) begin
                  rv[d] = 1'b1;
                  rid[d] = {2'd3, TW'($urandom)};
                  rlast[d] = 1'($urandom_range(0, 1));
               end
            end
         end
         step();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Parametrised N-channel request arbiter and return router between L1 cache clients and a single memory-adapter port.
- Clients are I$, D$, EBS store path and future accelerators.
- Generalises the fixed two-client I$/D$ plumbing:
  - arbitrary requestor count;
  - selectable round-robin or fixed-priority arbitration;
  - per-requestor outstanding-transaction limit;
  - ID-based return routing.
- Sits between the cache controllers and wt_axi_adapter / wt_l15_adapter.

Parameters:
- NumReq, 3, number of requestor channels (≥2); SrcW = $clog2(NumReq).
- TxIdWidth, 2, requestor-local transaction ID width.
- PayloadWidth, 96, opaque request payload width (address, size, data, type).
- RtrnWidth, 128, return data width.
- MaxOutstanding, 2, maximum in-flight transactions per requestor (1..15).
- FixedPrio, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  NumReq  per-requestor request; held high until acked.
- ack_o  out  NumReq  single-cycle acknowledge of the granted request.
- req_data_i  in  NumReq*PayloadWidth  request payload, slice k = requestor k.
- req_txid_i  in  NumReq*TxIdWidth  requestor-local transaction ID.
- mem_req_valid_o  out  1  request to adapter.
- mem_req_ready_i  in  1  adapter accepts request.
- mem_req_data_o  out  PayloadWidth  registered payload.
- mem_req_id_o  out  SrcW+TxIdWidth  {source index, local txid}.
- mem_rtrn_valid_i  in  1  return beat valid.
- mem_rtrn_id_i  in  SrcW+TxIdWidth  return ID.
- mem_rtrn_last_i  in  1  final beat of the transaction.
- mem_rtrn_data_i  in  RtrnWidth  return data.
- rtrn_vld_o  out  NumReq  one-hot return valid per requestor.
- rtrn_txid_o  out  TxIdWidth  local txid of the return.
- rtrn_data_o  out  RtrnWidth  return data, shared by all requestors.
- idle_o  out  1  no outstanding transactions and output register empty.
- rtrn_err_o  out  1  sticky: return with an illegal source or a zero outstanding count.

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - mem_req_valid_o=0, ack_o=0, rtrn_vld_o=0, rtrn_err_o=0, idle_o=1.
  - All outstanding counters 0; RR pointer 0.
  - In-flight transactions are dropped; returns arriving after reset with a zero count set rtrn_err_o.
- Eligibility: requestor k is eligible when req_i[k]=1 and cnt[k] < MaxOutstanding.
- Output stage is one register, states EMPTY / FULL:
  - EMPTY: if any requestor is eligible, grant one. Latch its payload and {k, txid}, pulse ack_o[k] in the same cycle, go to FULL. mem_req_valid_o is asserted from the next cycle, giving 1-cycle req-to-valid latency.
  - FULL: hold data/id stable while mem_req_ready_i=0.
    - On ready with no eligible requestor: go to EMPTY.
    - On ready with an eligible requestor: grant the new one in the same cycle and stay FULL (back-to-back, 1 transfer/cycle).
  - At most one ack_o bit high per cycle.
- Arbitration:
  - FixedPrio=1: lowest eligible index wins.
  - FixedPrio=0: search starts at the RR pointer. After a grant to k, the pointer becomes (k+1) mod NumReq, wrapping at NumReq-1 → 0. The pointer does not move without a grant.
- Outstanding counters:
  - +1 on grant to k.
  - -1 on mem_rtrn_valid_i & mem_rtrn_last_i with source k.
  - Simultaneous grant and last-return for the same k leaves the count unchanged.
  - No increment when the count equals MaxOutstanding (eligibility blocks it).
  - No decrement below 0; that case sets rtrn_err_o and the count stays 0.
- Return routing is combinational and zero-latency:
  - rtrn_vld_o[src] = mem_rtrn_valid_i for every beat.
  - rtrn_txid_o = id[TxIdWidth-1:0]; rtrn_data_o = mem_rtrn_data_i.
  - If src ≥ NumReq: rtrn_vld_o = 0 and rtrn_err_o is set.
- idle_o = all counters 0 and output stage EMPTY (registered).
- Clients must hold req_data_i/req_txid_i stable while req_i is high and not acked. Dropping req_i before ack is allowed only while the block is in reset.

Test Plan:
- RR fairness: NumReq=3, FixedPrio=0, req_i=3'b111 constant, ready=1, immediate returns → grants 0,1,2,0,1,2; one ack per cycle; mem_req_id_o source field follows the same order.
- Fixed priority: FixedPrio=1, req_i=3'b110 → requestor 1 is granted until cnt[1]=2, then requestor 2; requestor 0 raised later wins the next grant.
- Outstanding limit: MaxOutstanding=2, req_i[0] held, no returns → exactly 2 acks, then no ack. One last-beat return with id={0,txid} → exactly one further ack on the following grant cycle.
- Backpressure: mem_req_ready_i=0 for 5 cycles after a grant → mem_req_valid_o=1 and data/id stable for all 5 cycles; no further ack until ready rises; back-to-back transfer on the ready cycle.
- Routing and simultaneity: return id={2,2'b11} with last=1 in the same cycle as a grant to requestor 2 → rtrn_vld_o=3'b100, rtrn_txid_o=3, cnt[2] unchanged. Return id={3,x} with NumReq=3 → rtrn_vld_o=0, rtrn_err_o=1 (sticky).
- Reset mid-operation: assert rst_i while FULL with cnt={1,2,0} → next cycle mem_req_valid_o=0, idle_o=1. A later last-return for source 1 → rtrn_err_o=1.
